// File: rtl/sub_seq16.sv
//==============================================================================
// Module   : sub_seq16
// Brief    : Sequential 16-bit subtractor. It reuses one 4-bit sub4 slice,
//            processing one nibble per cycle. Defining SUB_SEQ16_OVF_EN adds
//            the signed-overflow output ovf.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] w_diff;

    // Bit 4 of the widened difference is the borrow out.
    assign w_diff = {1'b0, a} - {1'b0, b} - {4'b0000, ci};
    assign s      = w_diff[3:0];
    assign co     = w_diff[4];
endmodule

module sub_seq16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bi,
    output logic        busy,
    output logic        done,
    output logic [15:0] d,
    output logic        bo
`ifdef SUB_SEQ16_OVF_EN
    ,
    output logic        ovf
`endif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [1:0]  r_cnt;
    logic        r_brw;
    logic [15:0] r_d;
    logic        r_bo;
    logic        w_accept;
    logic        w_step;
    logic [3:0]  w_s;
    logic        w_co;
    logic [3:0]  w_sel;

    assign w_sel    = {r_cnt, 2'b00};
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_step   = (r_state == S_RUN) && !abort;

    sub4 u_sub4 (
        .a  (r_a[w_sel +: 4]),
        .b  (r_b[w_sel +: 4]),
        .ci (r_brw),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN: begin
                if (abort)              w_next = S_IDLE;
                else if (r_cnt == 2'd3) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_cnt   <= 2'd0;
            r_brw   <= 1'b0;
            r_d     <= 16'h0000;
            r_bo    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_cnt <= 2'd0;
                r_brw <= bi;
            end
            if (w_step) begin
                r_d[w_sel +: 4] <= w_s;
                r_brw           <= w_co;
                r_cnt           <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) r_bo <= w_co;
            end
        end
    end

`ifdef SUB_SEQ16_OVF_EN
    logic r_ovf;

    // Bit 15 of the result is produced by the final nibble, so take it from sub4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state != S_IDLE && abort) begin
            r_ovf <= 1'b0;
        end else if (w_step && r_cnt == 2'd3) begin
            r_ovf <= (r_a[15] != r_b[15]) && (w_s[3] != r_a[15]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE) && !abort;
    assign d    = r_d;
    assign bo   = r_bo;
endmodule

`default_nettype wire

// File: tb/tb_sub_seq16.sv
//==============================================================================
// Module   : tb_sub_seq16
// Brief    : Randomized self-checking bench for sub_seq16 against a wide
//            arithmetic reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sub_seq16;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        bo;
`ifdef SUB_SEQ16_OVF_EN
    logic        ovf;
`endif

    int tests;
    int fails;

    logic [15:0] model_d;
    logic        model_bo;
    logic        model_ovf;

    sub_seq16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SUB_SEQ16_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SUB_SEQ16_OVF_EN
        check(tag, 32'(ovf), 32'(exp));
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    function automatic logic [15:0] low_mask(input int nibbles);
        logic [16:0] m;
        m = (17'd1 << (4 * nibbles)) - 17'd1;
        return m[15:0];
    endfunction

    // Call with the time just after a falling edge; returns likewise.
    // abort_n < 0 means no abort; otherwise abort is raised after abort_n
    // RUN edges (4 = during DONE).
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbi,
                         input bit noise, input int abort_n);
        logic [16:0] diff;
        logic [15:0] m;
        logic        ovf_exp;
        logic [15:0] exp_d;
        logic        exp_bo;
        diff    = {1'b0, ta} - {1'b0, tb_v} - {16'd0, tbi};
        ovf_exp = (ta[15] != tb_v[15]) && (diff[15] != ta[15]);
        a = ta; b = tb_v; bi = tbi; start = 1'b1;
        abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            m      = (k >= 4) ? 16'hFFFF : low_mask(k);
            exp_d  = (model_d & ~m) | (diff[15:0] & m);
            exp_bo = (k >= 4) ? diff[16] : model_bo;
            check("busy", 32'(busy), 32'(k <= 4));
            check("done", 32'(done), 32'(k == 4));
            check("d", 32'(d), 32'(exp_d));
            check("bo", 32'(bo), 32'(exp_bo));
            check_ovf("ovf", (k >= 4) ? ovf_exp : 1'b0);
            start = (noise && k <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                bi = 1'($urandom_range(0, 1));
            end
            abort = 1'b0;
            if (k == abort_n) begin
                abort = 1'b1;
                start = 1'b0;
                #1;
                check("done_on_abort", 32'(done), 32'(0));
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                check("abort_d", 32'(d), 32'(exp_d));
                check("abort_bo", 32'(bo), 32'(exp_bo));
                check_ovf("abort_ovf", 1'b0);
                abort     = 1'b0;
                model_d   = exp_d;
                model_bo  = exp_bo;
                model_ovf = 1'b0;
                return;
            end
        end
        model_d   = diff[15:0];
        model_bo  = diff[16];
        model_ovf = ovf_exp;
    endtask

    task automatic reset_mid_run(input logic [15:0] ta, input logic [15:0] tb_v);
        a = ta; b = tb_v; bi = 1'b0; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_d", 32'(d), 32'(16'h0000));
        check("rst_bo", 32'(bo), 32'(0));
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_d", 32'(d), 32'(16'h0000));
        model_d = 16'h0000; model_bo = 1'b0; model_ovf = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a = 16'h0000; b = 16'h0000; bi = 1'b0;
        model_d = 16'h0000; model_bo = 1'b0; model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_d", 32'(d), 32'(16'h0000));
        check("reset_bo", 32'(bo), 32'(0));
        check_ovf("reset_ovf", 1'b0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_d", 32'(d), 32'(16'h0000));

        do_op(16'h1234, 16'h0234, 1'b0, 1'b0, -1);
        do_op(16'h0000, 16'h0001, 1'b0, 1'b0, -1);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b0, -1);
        do_op(16'h0005, 16'h0003, 1'b1, 1'b1, -1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, -1);
        do_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 2);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ab);
        end

        reset_mid_run(16'h1234, 16'h4321);
        do_op(16'h0100, 16'h0001, 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sub_seq16.md
SUB_SEQ16 -- requirements
Module: sub_seq16

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge); rst_n input 1 (reset sampled on clk rising edge, active low).
REQ-002 SHALL have start input 1: request to accept a new subtraction, honoured only in IDLE.
REQ-003 SHALL have abort input 1: cancels a running operation.
REQ-004 SHALL have a input 16: minuend, sampled at start acceptance.
REQ-005 SHALL have b input 16: subtrahend, sampled at start acceptance.
REQ-006 SHALL have bi input 1: borrow-in, sampled at start acceptance.
REQ-007 SHALL have busy output 1: high while state is not IDLE.
REQ-008 SHALL have done output 1: single-cycle completion pulse.
REQ-009 SHALL have d output 16: difference, registered.
REQ-010 SHALL have bo output 1: final borrow-out, registered.
REQ-011 SHALL have ovf output 1: signed overflow, present only when SUB_SEQ16_OVF_EN is defined.

Function
REQ-012 SHALL compute d = a - b - bi (mod 2^16) and bo = borrow out of bit 15, using exactly one instance of the existing 4-bit subtractor sub4, reused once per nibble.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start=1; RUN->DONE after nibble 3; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on start acceptance, latch a, b, bi into internal registers, clear the 2-bit nibble counter to 0 and load the borrow register with bi.
REQ-015 SHALL, in each RUN cycle with counter n, drive sub4 with a[4n+3:4n], b[4n+3:4n] and the borrow register, write sub4 s into d[4n+3:4n], load the borrow register with sub4 co, and increment n.
REQ-016 SHALL, on the RUN cycle with n=3, also load bo with sub4 co.
REQ-017 SHALL hold done=1 for exactly the DONE cycle; latency from the start-accepting edge to done high is 5 clock edges (4 RUN + 1).
REQ-018 SHALL ignore start while busy=1, including during DONE; inputs a, b, bi may change freely after acceptance.
REQ-019 SHALL keep d and bo stable from DONE until the next start acceptance; d SHALL update nibble by nibble during RUN.
REQ-020 SHALL, on abort=1 in RUN or DONE, go to IDLE on the next edge without pulsing done; d and bo keep their partially written values; abort in IDLE has no effect.
REQ-021 SHALL give abort priority over start when both are high in the same cycle; in IDLE the start is accepted (abort is a no-op there).

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set state IDLE, counter 0, borrow register 0, busy 0, done 0, d 16'h0000, bo 0, ovf 0, regardless of state, including mid-RUN.
REQ-023 SHALL leave all outputs at reset values until the first accepted start after rst_n returns high.

Configuration
REQ-024 SHALL, with SUB_SEQ16_OVF_EN defined, provide ovf registered in the DONE transition as (a15 != b15) && (d15 != a15) on the latched operands, held with d; abort leaves ovf at 0.
REQ-025 SHALL, without SUB_SEQ16_OVF_EN, omit the ovf port and its logic entirely; all other behaviour is identical.

Verification
REQ-026 a=16'h1234, b=16'h0234, bi=0, start pulse -> done 5 edges later, d=16'h1000, bo=0, busy high for 5 cycles.
REQ-027 a=16'h0000, b=16'h0001, bi=0 -> d=16'hFFFF, bo=1; with SUB_SEQ16_OVF_EN, ovf=0.
REQ-028 a=16'h8000, b=16'h0001, bi=0 with SUB_SEQ16_OVF_EN -> d=16'h7FFF, bo=0, ovf=1.
REQ-029 a=16'h0005, b=16'h0003, bi=1 -> d=16'h0001, bo=0; a second start pulse issued during RUN is ignored, and exactly one done is produced.
REQ-030 rst_n=0 during RUN cycle 2 -> next edge: busy=0, d=16'h0000, bo=0, no done pulse; abort during RUN -> IDLE, no done pulse, and a new start is accepted the following cycle.
